debouncer_botoes: RTL and testbench
===================================

Name: debouncer_botoes

Overview:
- Sits directly downstream of the clock divider. Consumes the divider's debounce-rate clock as a sampling reference; the block itself runs entirely in the system clock domain.
- Debounces the raw active-low floor-call pushbuttons.
- Emits a one-cycle press pulse per button.
- Holds latched floor calls until the elevator controller clears them.

Parameters:
- NUM_BOTOES, 4, number of buttons/floors handled (>=1).
- AMOSTRAS, 4, consecutive differing samples required before a stable level flips (>=1).

Ports:
- clock  input  1  system clock (board oscillator); all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clock_debounce  input  1  divided debounce-rate level from the clock divider; treated as data, never used as a clock.
- botoes_n  input  NUM_BOTOES  raw pushbuttons, active-low, asynchronous to clock.
- limpar_chamada  input  NUM_BOTOES  per-floor clear of latched call from controller, one-cycle or level.
- botoes_estaveis  output  NUM_BOTOES  debounced level, 1 = pressed.
- pulso_pressionado  output  NUM_BOTOES  one-cycle pulse on debounced 0->1.
- chamadas  output  NUM_BOTOES  latched floor calls.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Per-button counters 0.
  - Tick synchronizer stages 0; tick-previous register 0.
  - Button synchronizer stages all 1 (released), so no spurious press on reset release.
- Synchronizers:
  - clock_debounce passes through 2 flip-flops giving tick_s.
  - Each botoes_n bit passes through 2 flip-flops, then is inverted, giving amostra[i].
- Tick generation:
  - tick = tick_s & ~tick_ant; tick_ant is tick_s registered.
  - tick is high exactly one clock cycle per rising edge of clock_debounce.
  - Latency is 3 clocks after the clock_debounce edge.
  - If clock_debounce is held constant, no ticks occur.
- Per-button counter cnt[i] (width clog2(AMOSTRAS), min 1), evaluated only when tick=1:
  - If amostra[i] == botoes_estaveis[i]: cnt[i] <= 0.
  - Else if cnt[i] == AMOSTRAS-1: botoes_estaveis[i] flips and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - The flip therefore happens on the AMOSTRAS-th consecutive differing tick. Any agreeing tick restarts the count.
  - With AMOSTRAS=1, the stable level flips on the first differing tick.
  - When tick=0, cnt[i] and botoes_estaveis[i] hold.
- pulso_pressionado[i]:
  - Registered; asserted on the same clock edge on which botoes_estaveis[i] goes 0->1.
  - Exactly 1 cycle wide.
  - Never asserted on a 1->0 flip.
  - Independent per bit; multiple bits may pulse in the same cycle.
- chamadas[i]:
  - Set by pulso_pressionado[i].
  - Cleared by limpar_chamada[i] when no set is present.
  - Simultaneous set and clear on the same bit: set wins (no call lost).
  - Holds otherwise; a debounced release does not clear it.
- Reset asserted mid-count discards partial counts. After release, a full AMOSTRAS fresh ticks are required.
- No other arithmetic; counters never exceed AMOSTRAS-1 (no wrap).

Test Plan (NUM_BOTOES=4, AMOSTRAS=4, clock_debounce toggling every 8 clocks):
1. Reset: assert reset=0 with botoes_n=4'b0000 → all outputs 0, held through reset. Release reset with botoes_n=4'b1111 → no pulse, chamadas stays 4'b0000.
2. Clean press: botoes_n=4'b1011 held → after the 4th tick, botoes_estaveis=4'b0100 and pulso_pressionado=4'b0100 for exactly 1 cycle; chamadas=4'b0100.
3. Bounce: bit0 pressed for 2 ticks, released for 1 tick, pressed for 4 ticks → no change before the 4th tick of the final run; then a single pulse on bit0.
4. Release and clear: release bit2 → botoes_estaveis[2]=0 after 4 ticks with no pulse; chamadas[2] stays 1. limpar_chamada=4'b0100 for 1 cycle → chamadas=4'b0000.
5. Set/clear collision: bit1 pulse coincides with limpar_chamada=4'b0011 while chamadas=4'b0001 → chamadas=4'b0010.
6. Mid-operation reset / stuck tick:
   - Reset pulsed after 3 differing ticks → 4 new ticks needed before the flip.
   - clock_debounce held high for 100 clocks → no state change.

Source files
------------

// File: rtl/debouncer_botoes_if.sv
// rtl/debouncer_botoes_if.sv - pushbutton/call bus between board, debouncer and elevator controller
//
// Purpose: groups the debouncer's data-side signals so they travel as one port.
// Ports (signals):
//   clock_debounce     divided debounce-rate level (data, not a clock)
//   botoes_n           raw active-low pushbuttons, asynchronous
//   limpar_chamada     per-floor clear of a latched call
//   botoes_estaveis    debounced level, 1 = pressed
//   pulso_pressionado  one-cycle pulse on debounced press
//   chamadas           latched floor calls
// Modports: master = stimulus/controller side, slave = debouncer side.

interface debouncer_botoes_if #(
    parameter int NUM_BOTOES = 4
);
    logic                  clock_debounce;
    logic [NUM_BOTOES-1:0] botoes_n;
    logic [NUM_BOTOES-1:0] limpar_chamada;
    logic [NUM_BOTOES-1:0] botoes_estaveis;
    logic [NUM_BOTOES-1:0] pulso_pressionado;
    logic [NUM_BOTOES-1:0] chamadas;

    modport master (
        output clock_debounce,
        output botoes_n,
        output limpar_chamada,
        input  botoes_estaveis,
        input  pulso_pressionado,
        input  chamadas
    );

    modport slave (
        input  clock_debounce,
        input  botoes_n,
        input  limpar_chamada,
        output botoes_estaveis,
        output pulso_pressionado,
        output chamadas
    );
endinterface

// File: rtl/debouncer_botoes.sv
// rtl/debouncer_botoes.sv - floor-call pushbutton debouncer with press pulse and call latch
//
// Purpose: synchronizes raw active-low buttons, debounces them on ticks derived
// from the divider's debounce-rate level, pulses once per debounced press and
// holds the resulting floor call until the controller clears it.
// Ports:
//   clock  system clock, all state on rising edge
//   reset  asynchronous active-low reset
//   bus    debouncer_botoes_if.slave (clock_debounce, botoes_n, limpar_chamada in;
//          botoes_estaveis, pulso_pressionado, chamadas out)

module debouncer_botoes #(
    parameter int NUM_BOTOES = 4,
    parameter int AMOSTRAS   = 4
) (
    input  logic                clock,
    input  logic                reset,
    debouncer_botoes_if.slave   bus
);
    localparam int CNT_W = (AMOSTRAS > 1) ? $clog2(AMOSTRAS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AMOSTRAS - 1);

    logic [1:0]            tick_sync_q;
    logic                  tick_ant_q;
    logic                  tick;
    logic [NUM_BOTOES-1:0] btn_sync1_q;
    logic [NUM_BOTOES-1:0] btn_sync2_q;
    logic [NUM_BOTOES-1:0] amostra;

    logic [CNT_W-1:0]      cnt_q [NUM_BOTOES];
    logic [CNT_W-1:0]      cnt_d [NUM_BOTOES];
    logic [NUM_BOTOES-1:0] estaveis_q, estaveis_d;
    logic [NUM_BOTOES-1:0] pulso_q, pulso_d;
    logic [NUM_BOTOES-1:0] chamadas_q, chamadas_d;

    // Button synchronizers reset to "released" so leaving reset never looks
    // like a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_sync_q <= '0;
            tick_ant_q  <= 1'b0;
            btn_sync1_q <= '1;
            btn_sync2_q <= '1;
            estaveis_q  <= '0;
            pulso_q     <= '0;
            chamadas_q  <= '0;
            for (int i = 0; i < NUM_BOTOES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            tick_sync_q <= {tick_sync_q[0], bus.clock_debounce};
            tick_ant_q  <= tick_sync_q[1];
            btn_sync1_q <= bus.botoes_n;
            btn_sync2_q <= btn_sync1_q;
            estaveis_q  <= estaveis_d;
            pulso_q     <= pulso_d;
            chamadas_q  <= chamadas_d;
            for (int i = 0; i < NUM_BOTOES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        tick       = tick_sync_q[1] & ~tick_ant_q;
        amostra    = ~btn_sync2_q;
        estaveis_d = estaveis_q;
        for (int i = 0; i < NUM_BOTOES; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // A stable level flips only after AMOSTRAS consecutive disagreeing
        // ticks; any agreeing tick restarts the run.
        if (tick) begin
            for (int i = 0; i < NUM_BOTOES; i++) begin
                if (amostra[i] == estaveis_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    estaveis_d[i] = ~estaveis_q[i];
                    cnt_d[i]      = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        // Pulse lands on the same edge as the 0->1 stable flip.
        pulso_d = estaveis_d & ~estaveis_q;

        // Set has priority over clear so a press coinciding with a clear is kept.
        chamadas_d = (chamadas_q & ~bus.limpar_chamada) | pulso_q;
    end

    assign bus.botoes_estaveis   = estaveis_q;
    assign bus.pulso_pressionado = pulso_q;
    assign bus.chamadas          = chamadas_q;

endmodule

// File: tb/tb_debouncer_botoes.sv
// tb/tb_debouncer_botoes.sv - directed self-checking bench for debouncer_botoes

module tb_debouncer_botoes;
    logic clock;
    logic reset;
    logic run_cd;
    int   n_checks;
    int   n_errors;

    debouncer_botoes_if #(.NUM_BOTOES(4)) bus ();

    debouncer_botoes #(.NUM_BOTOES(4), .AMOSTRAS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Debounce-rate level toggles every 8 clocks while run_cd is set.
    initial begin
        bus.clock_debounce = 1'b0;
        forever begin
            repeat (8) @(negedge clock);
            if (run_cd) bus.clock_debounce = ~bus.clock_debounce;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Waits for the next clock_debounce rise and returns at the negedge where
    // that tick's effect (stable flip / pulse) is visible.
    task automatic wait_tick();
        logic p;
        int   n;
        p = bus.clock_debounce;
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            n++;
            if (bus.clock_debounce && !p) break;
            p = bus.clock_debounce;
        end
        if (n >= 40) check("tick_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) wait_tick();
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        run_cd             = 1'b1;
        reset              = 1'b0;
        bus.botoes_n       = 4'b0000;
        bus.limpar_chamada = 4'b0000;

        // 1. Reset held with all buttons low: outputs stay 0.
        repeat (40) @(negedge clock);
        check("rst_estaveis", 32'(bus.botoes_estaveis), 32'h0);
        check("rst_pulso", 32'(bus.pulso_pressionado), 32'h0);
        check("rst_chamadas", 32'(bus.chamadas), 32'h0);
        bus.botoes_n = 4'b1111;
        @(negedge clock);
        reset = 1'b1;
        wait_ticks(2);
        check("rel_estaveis", 32'(bus.botoes_estaveis), 32'h0);
        check("rel_chamadas", 32'(bus.chamadas), 32'h0);

        // 2. Clean press of bit2.
        bus.botoes_n = 4'b1011;
        wait_ticks(3);
        check("press_3tick", 32'(bus.botoes_estaveis), 32'h0);
        wait_tick();
        check("press_estaveis", 32'(bus.botoes_estaveis), 32'h4);
        check("press_pulso", 32'(bus.pulso_pressionado), 32'h4);
        @(negedge clock);
        check("press_pulso_end", 32'(bus.pulso_pressionado), 32'h0);
        check("press_chamadas", 32'(bus.chamadas), 32'h4);

        // 3. Bounce on bit0: 2 pressed, 1 released, then 4 pressed.
        bus.botoes_n = 4'b1010;
        wait_ticks(2);
        check("bounce_a", 32'(bus.botoes_estaveis), 32'h4);
        bus.botoes_n = 4'b1011;
        wait_tick();
        check("bounce_b", 32'(bus.botoes_estaveis), 32'h4);
        bus.botoes_n = 4'b1010;
        wait_ticks(3);
        check("bounce_c", 32'(bus.botoes_estaveis), 32'h4);
        check("bounce_c_pulso", 32'(bus.pulso_pressionado), 32'h0);
        wait_tick();
        check("bounce_estaveis", 32'(bus.botoes_estaveis), 32'h5);
        check("bounce_pulso", 32'(bus.pulso_pressionado), 32'h1);
        @(negedge clock);
        check("bounce_chamadas", 32'(bus.chamadas), 32'h5);

        // 4. Release bit2: no pulse, call held; then clear it.
        bus.botoes_n = 4'b1110;
        wait_ticks(3);
        check("relb2_3tick", 32'(bus.botoes_estaveis), 32'h5);
        wait_tick();
        check("relb2_estaveis", 32'(bus.botoes_estaveis), 32'h1);
        check("relb2_pulso", 32'(bus.pulso_pressionado), 32'h0);
        check("relb2_chamadas", 32'(bus.chamadas), 32'h5);
        bus.limpar_chamada = 4'b0100;
        @(negedge clock);
        bus.limpar_chamada = 4'b0000;
        check("clear_chamadas", 32'(bus.chamadas), 32'h1);

        // 5. Press bit1 while clearing bits 0 and 1 in the pulse cycle.
        bus.botoes_n = 4'b1100;
        wait_ticks(4);
        check("coll_pulso", 32'(bus.pulso_pressionado), 32'h2);
        bus.limpar_chamada = 4'b0011;
        @(negedge clock);
        bus.limpar_chamada = 4'b0000;
        check("coll_chamadas", 32'(bus.chamadas), 32'h2);

        // 6a. Reset after 3 differing ticks discards the partial count.
        bus.botoes_n = 4'b0111;
        wait_ticks(3);
        check("mid_pre", 32'(bus.botoes_estaveis), 32'h3);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_estaveis", 32'(bus.botoes_estaveis), 32'h0);
        check("mid_rst_chamadas", 32'(bus.chamadas), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        wait_ticks(3);
        check("mid_3tick", 32'(bus.botoes_estaveis), 32'h0);
        wait_tick();
        check("mid_estaveis", 32'(bus.botoes_estaveis), 32'h8);
        check("mid_pulso", 32'(bus.pulso_pressionado), 32'h8);
        @(negedge clock);
        check("mid_chamadas", 32'(bus.chamadas), 32'h8);

        // 6b. clock_debounce stuck high: no ticks, no change.
        run_cd       = 1'b0;
        bus.botoes_n = 4'b1111;
        repeat (100) @(negedge clock);
        check("stuck_estaveis", 32'(bus.botoes_estaveis), 32'h8);
        check("stuck_pulso", 32'(bus.pulso_pressionado), 32'h0);
        run_cd = 1'b1;
        wait_ticks(4);
        check("unstuck_estaveis", 32'(bus.botoes_estaveis), 32'h0);
        check("unstuck_pulso", 32'(bus.pulso_pressionado), 32'h0);
        check("unstuck_chamadas", 32'(bus.chamadas), 32'h8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
